// File: rtl/frame_downscale_2x.sv
`default_nettype none
// ============================================================================
// Module      : frame_downscale_2x
// Description : Streaming 2x2 box-average decimator. Consumes a raster-order
//               pixel stream (FRAME_WIDTH x FRAME_HEIGHT) and emits one
//               rounded average per 2x2 block, tagged with its destination
//               coordinate.
// Ports       : clk_fpga      - clock, rising edge
//               reset_fpga    - asynchronous active-low reset
//               wen           - input pixel valid
//               sof           - start of frame (qualified by wen)
//               pixel         - source pixel
//               o_valid       - one-cycle pulse per completed 2x2 block
//               o_pixel       - averaged pixel, round half up
//               o_xcoord      - destination column
//               o_ycoord      - destination row
//               o_frame_done  - pulses with the frame's last output
//               o_sync_err    - sof seen while source counters not at (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_downscale_2x #(
    parameter int DATA_WIDTH   = 8,
    parameter int COORD_WIDTH  = 16,
    parameter int FRAME_WIDTH  = 10,
    parameter int FRAME_HEIGHT = 10
) (
    input  logic                   clk_fpga,
    input  logic                   reset_fpga,
    input  logic                   wen,
    input  logic                   sof,
    input  logic [DATA_WIDTH-1:0]  pixel,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_pixel,
    output logic [COORD_WIDTH-1:0] o_xcoord,
    output logic [COORD_WIDTH-1:0] o_ycoord,
    output logic                   o_frame_done,
    output logic                   o_sync_err
);

    localparam int LB_DEPTH = FRAME_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COORD_WIDTH-1:0]  C_SX_LAST = COORD_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0]  C_SY_LAST = COORD_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0]  C_ONE     = COORD_WIDTH'(1);
    localparam logic [DATA_WIDTH+1:0]   C_ROUND   = (DATA_WIDTH + 2)'(2);

    logic [COORD_WIDTH-1:0] r_sx;
    logic [COORD_WIDTH-1:0] r_sy;
    logic [DATA_WIDTH-1:0]  r_pair;
    logic [DATA_WIDTH:0]    r_linebuf [LB_DEPTH];

    logic [COORD_WIDTH-1:0] w_sx;
    logic [COORD_WIDTH-1:0] w_sy;
    logic [LB_AW-1:0]       w_lb_idx;
    logic [DATA_WIDTH:0]    w_pair_sum;
    logic [DATA_WIDTH:0]    w_lb_rd;
    logic [DATA_WIDTH+1:0]  w_total_rnd;
    logic [DATA_WIDTH-1:0]  w_avg;
    logic                   w_not_origin;
    logic                   w_sx_last;
    logic                   w_sy_last;

    // A sof-qualified pixel is always treated as source (0,0), so the
    // effective position overrides the running counters for this pixel.
    assign w_sx         = sof ? '0 : r_sx;
    assign w_sy         = sof ? '0 : r_sy;
    assign w_not_origin = (r_sx != '0) || (r_sy != '0);
    assign w_sx_last    = (w_sx == C_SX_LAST);
    assign w_sy_last    = (w_sy == C_SY_LAST);

    assign w_lb_idx    = w_sx[LB_AW:1];
    assign w_pair_sum  = {1'b0, r_pair} + {1'b0, pixel};
    assign w_lb_rd     = r_linebuf[w_lb_idx];
    // Max total is 4*(2^DATA_WIDTH-1)+2, which still fits in DATA_WIDTH+2 bits.
    assign w_total_rnd = {1'b0, w_lb_rd} + {1'b0, w_pair_sum} + C_ROUND;
    assign w_avg       = DATA_WIDTH'(w_total_rnd >> 2);

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            r_sx         <= '0;
            r_sy         <= '0;
            r_pair       <= '0;
            o_valid      <= 1'b0;
            o_pixel      <= '0;
            o_xcoord     <= '0;
            o_ycoord     <= '0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
            if (wen) begin
                o_sync_err <= sof && w_not_origin;

                if (!w_sx[0]) begin
                    r_pair <= pixel;
                end else if (w_sy[0]) begin
                    o_valid      <= 1'b1;
                    o_pixel      <= w_avg;
                    o_xcoord     <= w_sx >> 1;
                    o_ycoord     <= w_sy >> 1;
                    o_frame_done <= w_sx_last && w_sy_last;
                end

                if (w_sx_last) begin
                    r_sx <= '0;
                    r_sy <= w_sy_last ? '0 : (w_sy + C_ONE);
                end else begin
                    r_sx <= w_sx + C_ONE;
                    r_sy <= w_sy;
                end
            end
        end
    end

    // Line buffer holds the horizontal pair sums of the even row; it is
    // fully rewritten on every even row, so it needs no reset.
    always_ff @(posedge clk_fpga) begin
        if (wen && w_sx[0] && !w_sy[0]) begin
            r_linebuf[w_lb_idx] <= w_pair_sum;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_downscale_2x.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_downscale_2x
// Description : Scoreboard bench for frame_downscale_2x. The driver pushes
//               expected outputs and sync-error cycles into queues; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_downscale_2x;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int FW = 10;
    localparam int FH = 10;

    logic          clk_fpga   = 1'b0;
    logic          reset_fpga = 1'b0;
    logic          wen        = 1'b0;
    logic          sof        = 1'b0;
    logic [DW-1:0] pixel      = '0;
    logic          o_valid;
    logic [DW-1:0] o_pixel;
    logic [CW-1:0] o_xcoord;
    logic [CW-1:0] o_ycoord;
    logic          o_frame_done;
    logic          o_sync_err;

    frame_downscale_2x #(
        .DATA_WIDTH  (DW),
        .COORD_WIDTH (CW),
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH)
    ) dut (
        .clk_fpga    (clk_fpga),
        .reset_fpga  (reset_fpga),
        .wen         (wen),
        .sof         (sof),
        .pixel       (pixel),
        .o_valid     (o_valid),
        .o_pixel     (o_pixel),
        .o_xcoord    (o_xcoord),
        .o_ycoord    (o_ycoord),
        .o_frame_done(o_frame_done),
        .o_sync_err  (o_sync_err)
    );

    always #5 clk_fpga = ~clk_fpga;

    int cyc = 0;
    always @(posedge clk_fpga) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int pix;
        int done;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   sq[$];
    int   errors = 0;
    int   checks = 0;
    int   img  [FH][FW];
    int   sent [FH][FW];
    int   sx_m = 0;
    int   sy_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of input; when the pixel is accepted, update the
    // position model and queue any expected output.
    task automatic drive(input bit w, input bit s, input logic [DW-1:0] p);
        exp_t e;
        @(negedge clk_fpga);
        wen   = w;
        sof   = s;
        pixel = p;
        if (w) begin
            if (s) begin
                if (sx_m != 0 || sy_m != 0) sq.push_back(cyc + 1);
                sx_m = 0;
                sy_m = 0;
            end
            sent[sy_m][sx_m] = int'(p);
            if ((sx_m % 2 == 1) && (sy_m % 2 == 1)) begin
                e.x    = sx_m / 2;
                e.y    = sy_m / 2;
                e.pix  = (sent[sy_m-1][sx_m-1] + sent[sy_m-1][sx_m] +
                          sent[sy_m][sx_m-1]   + sent[sy_m][sx_m] + 2) / 4;
                e.done = (sx_m == FW-1 && sy_m == FH-1) ? 1 : 0;
                e.cyc  = cyc + 1;
                q.push_back(e);
            end
            if (sx_m == FW-1) begin
                sx_m = 0;
                sy_m = (sy_m == FH-1) ? 0 : sy_m + 1;
            end else begin
                sx_m = sx_m + 1;
            end
        end
    endtask

    // Send the first n raster pixels of img, sof on pixel 0, with idle gaps.
    task automatic send_pixels(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct)
                drive(1'b0, 1'($urandom_range(1)), DW'($urandom));
            drive(1'b1, (i == 0), DW'(img[i / FW][i % FW]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_valid),      0);
        chk({tag, "_pixel"}, 32'(o_pixel),      0);
        chk({tag, "_x"},     32'(o_xcoord),     0);
        chk({tag, "_y"},     32'(o_ycoord),     0);
        chk({tag, "_done"},  32'(o_frame_done), 0);
        chk({tag, "_serr"},  32'(o_sync_err),   0);
    endtask

    exp_t m_e;
    always @(negedge clk_fpga) begin
        if (o_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pixel %0d at (%0d,%0d) expected no output",
                         o_pixel, o_xcoord, o_ycoord);
            end else begin
                m_e = q.pop_front();
                chk("out_x",       32'(o_xcoord),     m_e.x);
                chk("out_y",       32'(o_ycoord),     m_e.y);
                chk("out_pixel",   32'(o_pixel),      m_e.pix);
                chk("out_done",    32'(o_frame_done), m_e.done);
                chk("out_latency", cyc,               m_e.cyc);
            end
        end else if (o_frame_done) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid: got 1 expected 0");
        end
        if (o_sync_err) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sync_err: got 1 expected 0");
            end else begin
                chk("sync_err_cycle", cyc, sq.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check_outputs_zero("reset");
        @(negedge clk_fpga);
        reset_fpga = 1'b1;

        // Flat frame of 100
        for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) img[y][x] = 100;
        send_pixels(FW*FH, 0);

        // Ramp frame, continuous; dst (X,Y) averages to 20Y+2X+6
        for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) img[y][x] = y*10 + x;
        send_pixels(FW*FH, 0);

        // Rounding / saturation blocks in the top destination row
        for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) img[y][x] = (x + 3*y) % 7;
        img[0][0] = 0;   img[0][1] = 0;   img[1][0] = 0;   img[1][1] = 2;
        img[0][2] = 0;   img[0][3] = 0;   img[1][2] = 0;   img[1][3] = 1;
        img[0][4] = 255; img[0][5] = 255; img[1][4] = 255; img[1][5] = 255;
        send_pixels(FW*FH, 0);

        // Ramp with ~50% idle cycles (idle cycles also carry stray sof)
        for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) img[y][x] = y*10 + x;
        send_pixels(FW*FH, 50);
        idle(2);

        // Abort at source (3,4), then a fresh inverted-ramp frame
        send_pixels(4*FW + 3, 0);
        for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) img[y][x] = 255 - (y*10 + x);
        send_pixels(FW*FH, 0);

        // Asynchronous reset mid-frame, away from clock edges
        for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) img[y][x] = y*10 + x;
        send_pixels(5*FW + 5, 0);
        idle(2);
        chk("queue_before_reset", q.size(), 0);
        @(posedge clk_fpga);
        #3;
        reset_fpga = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        sx_m = 0;
        sy_m = 0;
        #20;
        @(negedge clk_fpga);
        reset_fpga = 1'b1;
        for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) img[y][x] = (x*37 + y*11) % 256;
        send_pixels(FW*FH, 0);

        // Drain with a bounded wait
        drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk_fpga);
        @(negedge clk_fpga);
        chk("pending_outputs", q.size(), 0);
        chk("pending_sync_err", sq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
